// File: rtl/aes_ctr_sequencer.sv
// AES-CTR job sequencer: pops plaintext blocks, runs the shared AES core on
// the running counter block, XORs in the keystream and presents ciphertext
// beats with incrementing destination addresses to the master write port.
module aes_ctr_sequencer #(
    parameter int CTR_WIDTH = 32
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         start,
    input  logic         abort,
    input  logic [15:0]  job_len,
    input  logic [127:0] cfg_key,
    input  logic [127:0] cfg_nonce,
    input  logic [31:0]  cfg_dest,
    input  logic         fifo_empty,
    input  logic [127:0] fifo_rdata,
    output logic         fifo_read,
    output logic         aes_start,
    output logic [127:0] aes_key,
    output logic [127:0] aes_block_in,
    input  logic         aes_done,
    input  logic [127:0] aes_block_out,
    output logic         out_valid,
    output logic [127:0] out_data,
    output logic [31:0]  out_addr,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        ENC_REQ  = 3'd2,
        ENC_WAIT = 3'd3,
        OUT      = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Selects the low CTR_WIDTH bits that form the incrementing counter field.
    // For CTR_WIDTH=128 the shift yields 0 and the subtraction all ones.
    localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

    state_t        state, nxt;
    logic [127:0]  key_r, ctr_r, pt_r, ct_r;
    logic [31:0]   addr_r;
    logic [15:0]   rem_r;
    logic          avail_r;
    logic          start_job, beat_ok;

    // avail_r is the FIFO non-empty flag from the previous cycle. The FIFO has
    // no other consumer, so once non-empty it stays non-empty until we pop;
    // gating the pop with this flop keeps fifo_empty off the fifo_read path.
    assign fifo_read    = (state == FETCH) && avail_r;
    assign aes_start    = (state == ENC_REQ);
    assign out_valid    = (state == OUT);
    assign done         = (state == DONE);
    assign busy         = (state != IDLE);
    assign aes_key      = key_r;
    assign aes_block_in = ctr_r;
    assign out_data     = ct_r;
    assign out_addr     = addr_r;

    assign start_job = (state == IDLE) && start && (job_len != 16'd0);
    assign beat_ok   = out_valid && out_ready;

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= nxt;
    end

    // Next-state logic; abort wins everywhere except IDLE.
    always_comb begin
        nxt = state;
        if (state != IDLE && abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (start) nxt = (job_len == 16'd0) ? DONE : FETCH;
                FETCH:    if (fifo_read) nxt = ENC_REQ;
                ENC_REQ:  nxt = ENC_WAIT;
                ENC_WAIT: if (aes_done) nxt = OUT;
                OUT:      if (out_ready) nxt = (rem_r == 16'd1) ? DONE : FETCH;
                DONE:     nxt = IDLE;
                default:  nxt = IDLE;
            endcase
        end
    end

    // Job datapath: latch config, capture plaintext/ciphertext, advance per beat.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            key_r   <= '0;
            ctr_r   <= '0;
            pt_r    <= '0;
            ct_r    <= '0;
            addr_r  <= '0;
            rem_r   <= '0;
            avail_r <= 1'b0;
        end else begin
            avail_r <= !fifo_empty;
            if (start_job) begin
                key_r  <= cfg_key;
                ctr_r  <= cfg_nonce;
                addr_r <= cfg_dest;
                rem_r  <= job_len;
            end
            if (fifo_read) pt_r <= fifo_rdata;
            if (state == ENC_WAIT && aes_done) ct_r <= pt_r ^ aes_block_out;
            if (beat_ok) begin
                ctr_r  <= (ctr_r & ~CTR_MASK) | ((ctr_r + 128'd1) & CTR_MASK);
                addr_r <= addr_r + 32'd16;
                rem_r  <= rem_r - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Directed bench for aes_ctr_sequencer with a behavioural FIFO and AES core.
module tb_aes_ctr_sequencer;

    logic         HCLK, HRESETn, start, abort, fifo_empty, aes_done, out_ready;
    logic [15:0]  job_len;
    logic [127:0] cfg_key, cfg_nonce, fifo_rdata, aes_block_out;
    logic [31:0]  cfg_dest;
    logic         fifo_read, aes_start, out_valid, busy, done;
    logic [127:0] aes_key, aes_block_in, out_data;
    logic [31:0]  out_addr;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] P0  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] P1  = 128'hdeadbeef_01234567_89abcdef_feedface;
    localparam logic [127:0] P2  = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] P3  = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] P4  = 128'hcafef00d_00000001_00000002_00000003;
    localparam logic [127:0] KS  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] K1  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] UPW = 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_00000000;

    aes_ctr_sequencer #(.CTR_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort),
        .job_len(job_len), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
        .cfg_dest(cfg_dest), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_read(fifo_read), .aes_start(aes_start), .aes_key(aes_key),
        .aes_block_in(aes_block_in), .aes_done(aes_done),
        .aes_block_out(aes_block_out), .out_valid(out_valid),
        .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Behavioural show-ahead FIFO: only this process drives its outputs.
    logic [127:0] fq[$];
    logic         rd_s;
    initial begin
        fifo_empty = 1'b1;
        fifo_rdata = '0;
    end
    always @(posedge HCLK) begin
        rd_s = fifo_read;
        #3;
        if (rd_s && fq.size() > 0) fq.delete(0);
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() > 0) ? fq[0] : '0;
    end

    // Behavioural AES core: aes_done lands aes_lat cycles after the aes_start cycle.
    int           aes_lat = 4;
    int           pend = 0;
    logic [127:0] ks;
    logic         st_s;
    initial begin
        aes_done = 1'b0;
        aes_block_out = '0;
        ks = '1;
    end
    always @(posedge HCLK) begin
        st_s = aes_start;
        #3;
        aes_done = 1'b0;
        if (st_s) pend = aes_lat;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                aes_done = 1'b1;
                aes_block_out = ks;
            end
        end
    end

    // Event monitor: cyc labels the cycle that ends at that rising edge.
    int           cyc = 0;
    int           pop_cyc[$], ast_cyc[$], beat_cyc[$], done_cyc[$];
    logic [127:0] ast_blk[$], beat_data[$];
    logic [31:0]  beat_addr[$];
    int           pop_empty = 0, stall_viol = 0;
    logic         hold_p = 1'b0;
    logic [127:0] hold_d;
    logic [31:0]  hold_a;
    always @(posedge HCLK) begin
        cyc++;
        if (HRESETn) begin
            if (fifo_read) begin
                pop_cyc.push_back(cyc);
                if (fifo_empty) pop_empty++;
            end
            if (aes_start) begin
                ast_cyc.push_back(cyc);
                ast_blk.push_back(aes_block_in);
            end
            if (out_valid && out_ready) begin
                beat_cyc.push_back(cyc);
                beat_data.push_back(out_data);
                beat_addr.push_back(out_addr);
            end
            if (done) done_cyc.push_back(cyc);
            if (hold_p && (!out_valid || out_data !== hold_d || out_addr !== hold_a)) stall_viol++;
            hold_p = out_valid && !out_ready;
            hold_d = out_data;
            hold_a = out_addr;
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        pop_cyc.delete(); ast_cyc.delete(); beat_cyc.delete(); done_cyc.delete();
        ast_blk.delete(); beat_data.delete(); beat_addr.delete();
        pop_empty = 0;
        stall_viol = 0;
    endtask

    // Pulses start for one cycle; s is the label of the edge that samples it.
    task automatic launch(input logic [15:0] len, input logic [127:0] key,
                          input logic [127:0] nonce, input logic [31:0] dest,
                          output int s);
        job_len = len; cfg_key = key; cfg_nonce = nonce; cfg_dest = dest;
        start = 1'b1;
        s = cyc + 1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        run(2);
        checks++;
        if ({fifo_read, aes_start, out_valid, busy, done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {fifo_read, aes_start, out_valid, busy, done});
        end
        HRESETn = 1'b1;
        run(2);
        checks++;
        if ({aes_key, aes_block_in, out_data, out_addr} !== '0) begin
            errors++; $display("FAIL reset_data got key=%h blk=%h data=%h addr=%h exp 0", aes_key, aes_block_in, out_data, out_addr);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int s;
        clear_logs();
        aes_lat = 4; ks = '1; out_ready = 1'b1;
        fq.push_back(P0); fq.push_back(P1);
        launch(2, K1, 128'h5, 32'h1000, s);
        checks++;
        if (fifo_read !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_fetch got rd=%b busy=%b exp 1 1", fifo_read, busy);
        end
        run(20);
        checks++;
        if (pop_cyc.size() != 2 || pop_cyc[0] != s + 1 || pop_cyc[1] != s + 8) begin
            errors++; $display("FAIL basic_pops got n=%0d first=%0d exp 2 at %0d,%0d", pop_cyc.size(), pop_cyc[0], s + 1, s + 8);
        end
        checks++;
        if (ast_cyc.size() != 2 || ast_cyc[0] != s + 2 || ast_blk[0] !== 128'h5 || ast_blk[1] !== 128'h6) begin
            errors++; $display("FAIL basic_aes got n=%0d c=%0d b0=%h b1=%h exp 2 %0d 5 6", ast_cyc.size(), ast_cyc[0], ast_blk[0], ast_blk[1], s + 2);
        end
        checks++;
        if (beat_cyc.size() != 2 || beat_cyc[0] != s + 7 || beat_cyc[1] != s + 14) begin
            errors++; $display("FAIL basic_beat_cyc got n=%0d c0=%0d c1=%0d exp 2 %0d %0d", beat_cyc.size(), beat_cyc[0], beat_cyc[1], s + 7, s + 14);
        end
        checks++;
        if (beat_data[0] !== ~P0 || beat_data[1] !== ~P1 || beat_addr[0] !== 32'h1000 || beat_addr[1] !== 32'h1010) begin
            errors++; $display("FAIL basic_beats got %h@%h %h@%h exp %h@1000 %h@1010", beat_data[0], beat_addr[0], beat_data[1], beat_addr[1], ~P0, ~P1);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 15) begin
            errors++; $display("FAIL basic_done got n=%0d c=%0d exp 1 %0d", done_cyc.size(), done_cyc[0], s + 15);
        end
        checks++;
        if (busy !== 1'b0 || aes_key !== K1) begin
            errors++; $display("FAIL basic_end got busy=%b key=%h exp 0 %h", busy, aes_key, K1);
        end
    endtask

    task automatic test_wrap();
        int s;
        clear_logs();
        aes_lat = 1; ks = KS; out_ready = 1'b1;
        fq.push_back(P2); fq.push_back(P3);
        launch(2, ~K1, UPW | 128'hffff_ffff, 32'hffff_fff0, s);
        run(15);
        checks++;
        if (ast_blk.size() != 2 || ast_blk[0] !== (UPW | 128'hffff_ffff) || ast_blk[1] !== UPW) begin
            errors++; $display("FAIL wrap_ctr got b0=%h b1=%h exp %h %h", ast_blk[0], ast_blk[1], UPW | 128'hffff_ffff, UPW);
        end
        checks++;
        if (beat_addr.size() != 2 || beat_addr[0] !== 32'hffff_fff0 || beat_addr[1] !== 32'h0) begin
            errors++; $display("FAIL wrap_addr got %h %h exp fffffff0 00000000", beat_addr[0], beat_addr[1]);
        end
        checks++;
        if (beat_data[0] !== (P2 ^ KS) || beat_data[1] !== (P3 ^ KS)) begin
            errors++; $display("FAIL wrap_data got %h %h exp %h %h", beat_data[0], beat_data[1], P2 ^ KS, P3 ^ KS);
        end
        checks++;
        if (beat_cyc[0] != s + 4 || beat_cyc[1] != s + 8 || done_cyc.size() != 1 || done_cyc[0] != s + 9) begin
            errors++; $display("FAIL wrap_timing got b=%0d,%0d d=%0d exp %0d,%0d d=%0d", beat_cyc[0], beat_cyc[1], done_cyc[0], s + 4, s + 8, s + 9);
        end
        checks++;
        if (aes_key !== ~K1) begin
            errors++; $display("FAIL wrap_key got %h exp %h", aes_key, ~K1);
        end
    endtask

    task automatic test_backpressure();
        int s;
        logic [127:0] d0;
        logic [31:0] a0;
        logic hold_ok;
        clear_logs();
        aes_lat = 2; ks = KS; out_ready = 1'b0;
        launch(1, K1, 128'h100, 32'h4000, s);
        run(4);
        checks++;
        if (pop_cyc.size() != 0) begin
            errors++; $display("FAIL bp_nopop got %0d pops exp 0", pop_cyc.size());
        end
        fq.push_back(P4);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_timeout got out_valid=%b exp 1", out_valid);
        end
        d0 = out_data; a0 = out_addr;
        checks++;
        if (d0 !== (P4 ^ KS) || a0 !== 32'h4000) begin
            errors++; $display("FAIL bp_beat got %h@%h exp %h@4000", d0, a0, P4 ^ KS);
        end
        hold_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!(out_valid === 1'b1 && out_data === d0 && out_addr === a0)) hold_ok = 1'b0;
        end
        checks++;
        if (hold_ok !== 1'b1) begin
            errors++; $display("FAIL bp_hold got %b exp 1", hold_ok);
        end
        out_ready = 1'b1;
        run(4);
        checks++;
        if (beat_cyc.size() != 1 || done_cyc.size() != 1) begin
            errors++; $display("FAIL bp_count got beats=%0d dones=%0d exp 1 1", beat_cyc.size(), done_cyc.size());
        end
        checks++;
        if (pop_cyc.size() != 1 || pop_empty != 0 || stall_viol != 0) begin
            errors++; $display("FAIL bp_proto got pops=%0d pop_empty=%0d viol=%0d exp 1 0 0", pop_cyc.size(), pop_empty, stall_viol);
        end
    endtask

    task automatic test_abort();
        int s;
        logic [127:0] d_before;
        clear_logs();
        aes_lat = 6; ks = KS; out_ready = 1'b1;
        fq.push_back(P0); fq.push_back(P1);
        launch(2, K1, 128'h77, 32'h3000, s);
        run(2);
        checks++;
        if (busy !== 1'b1 || aes_start !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_pre got busy=%b ast=%b ov=%b exp 1 0 0", busy, aes_start, out_valid);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        d_before = out_data;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL abort_busy got %b exp 0", busy);
        end
        run(10);
        checks++;
        if (beat_cyc.size() != 0 || done_cyc.size() != 0 || pop_cyc.size() != 1) begin
            errors++; $display("FAIL abort_quiet got beats=%0d dones=%0d pops=%0d exp 0 0 1", beat_cyc.size(), done_cyc.size(), pop_cyc.size());
        end
        checks++;
        if (out_data !== d_before || busy !== 1'b0) begin
            errors++; $display("FAIL abort_late_done got data=%h busy=%b exp %h 0", out_data, busy, d_before);
        end
        clear_logs();
        aes_lat = 2;
        launch(1, K1, 128'h900, 32'h2000, s);
        run(12);
        checks++;
        if (beat_data.size() != 1 || beat_data[0] !== (P1 ^ KS) || beat_addr[0] !== 32'h2000) begin
            errors++; $display("FAIL abort_next_beat got n=%0d %h@%h exp 1 %h@2000", beat_data.size(), beat_data[0], beat_addr[0], P1 ^ KS);
        end
        checks++;
        if (ast_blk.size() != 1 || ast_blk[0] !== 128'h900 || done_cyc.size() != 1) begin
            errors++; $display("FAIL abort_next_job got n=%0d blk=%h dones=%0d exp 1 900 1", ast_blk.size(), ast_blk[0], done_cyc.size());
        end
    endtask

    task automatic test_edges();
        int s;
        clear_logs();
        out_ready = 1'b1;
        launch(0, K1, 128'h1, 32'h0, s);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL zero_done got done=%b busy=%b exp 1 1", done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_idle got done=%b busy=%b exp 0 0", done, busy);
        end
        run(3);
        checks++;
        if (ast_cyc.size() != 0 || pop_cyc.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != s + 1) begin
            errors++; $display("FAIL zero_quiet got ast=%0d pops=%0d dones=%0d exp 0 0 1", ast_cyc.size(), pop_cyc.size(), done_cyc.size());
        end
        // Extra starts while busy must not reload length, nonce or destination.
        clear_logs();
        aes_lat = 2; ks = KS;
        fq.push_back(P2); fq.push_back(P3); fq.push_back(P4);
        launch(2, K1, 128'h40, 32'h5000, s);
        start = 1'b1; job_len = 16'd5; cfg_nonce = 128'hbad; cfg_dest = 32'hdead0000;
        run(3);
        start = 1'b0;
        run(25);
        checks++;
        if (beat_cyc.size() != 2 || pop_cyc.size() != 2 || done_cyc.size() != 1) begin
            errors++; $display("FAIL busy_start_count got beats=%0d pops=%0d dones=%0d exp 2 2 1", beat_cyc.size(), pop_cyc.size(), done_cyc.size());
        end
        checks++;
        if (ast_blk[1] !== 128'h41 || beat_addr[1] !== 32'h5010) begin
            errors++; $display("FAIL busy_start_cfg got blk=%h addr=%h exp 41 5010", ast_blk[1], beat_addr[1]);
        end
        // abort together with start in IDLE: the job still starts.
        clear_logs();
        aes_lat = 1;
        abort = 1'b1;
        launch(1, K1, 128'h60, 32'h6000, s);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL abort_start got busy=%b exp 1", busy);
        end
        run(10);
        checks++;
        if (beat_data.size() != 1 || beat_data[0] !== (P4 ^ KS) || done_cyc.size() != 1) begin
            errors++; $display("FAIL abort_start_job got n=%0d data=%h dones=%0d exp 1 %h 1", beat_data.size(), beat_data[0], done_cyc.size(), P4 ^ KS);
        end
    endtask

    task automatic test_async_reset();
        int s;
        clear_logs();
        aes_lat = 1; ks = KS; out_ready = 1'b0;
        fq.push_back(P0);
        launch(1, K1, 128'h80, 32'h7000, s);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL areset_timeout got out_valid=%b exp 1", out_valid);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({fifo_read, aes_start, out_valid, busy, done} !== 5'b0 ||
            {aes_key, aes_block_in, out_data, out_addr} !== '0) begin
            errors++; $display("FAIL areset_outputs got ctl=%b data=%h addr=%h exp 0 0 0", {fifo_read, aes_start, out_valid, busy, done}, out_data, out_addr);
        end
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        out_ready = 1'b1;
        run(3);
        checks++;
        if (busy !== 1'b0 || done_cyc.size() != 0 || beat_cyc.size() != 0) begin
            errors++; $display("FAIL areset_idle got busy=%b dones=%0d beats=%0d exp 0 0 0", busy, done_cyc.size(), beat_cyc.size());
        end
    endtask

    initial begin
        HRESETn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        job_len = '0; cfg_key = '0; cfg_nonce = '0; cfg_dest = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_abort();
        test_edges();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
